hd_serial_alu: RTL and testbench

//   Digit-serial, parametrised two-operand arithmetic unit for Hacker's Delight kernels:
//   add, subtract, floor-average, unsigned max.

---
 rtl/hd_serial_pkg.sv | 57 +++++
 rtl/hd_digit_adder.sv | 16 +
 rtl/hd_serial_alu.sv | 132 +++++++++++++
 tb/tb_hd_serial_alu.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd_serial_pkg.sv
// Shared types and operand-preparation helper for the digit-serial Hacker's Delight ALU.
package hd_serial_pkg;

    // Widest operand the preparation helper handles; instances narrow it with width casts.
    localparam int unsigned HD_MAX_W = 64;

    typedef enum logic [1:0] {
        HD_ADD  = 2'b00,
        HD_SUB  = 2'b01,
        HD_AVGF = 2'b10,
        HD_MAXU = 2'b11
    } hd_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [HD_MAX_W-1:0] hd_word_t;

    // Operand pair fed to the serial adder plus its carry-in.
    typedef struct packed {
        hd_word_t x;
        hd_word_t y;
        logic     c0;
    } hd_prep_t;

    // Map (op, a, b) onto a single add: x + y + c0.
    // SUB and MAXU both compute a + ~b + 1, whose carry-out means a >= b.
    // AVGF uses (a & b) + ((a ^ b) >> 1), which is floor((a + b) / 2) without overflow.
    function automatic hd_prep_t hd_prep(input hd_op_e op, input hd_word_t a, input hd_word_t b);
        hd_prep_t p;
        p.x  = a;
        p.y  = b;
        p.c0 = 1'b0;
        case (op)
            HD_ADD: begin
                p.x  = a;
                p.y  = b;
                p.c0 = 1'b0;
            end
            HD_SUB, HD_MAXU: begin
                p.x  = a;
                p.y  = ~b;
                p.c0 = 1'b1;
            end
            HD_AVGF: begin
                p.x  = a & b;
                p.y  = (a ^ b) >> 1;
                p.c0 = 1'b0;
            end
        endcase
        return p;
    endfunction

endpackage

// File: rtl/hd_digit_adder.sv
// Combinational DIGIT-bit adder slice with carry in/out; reused every RUN cycle.
module hd_digit_adder #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);
    localparam int unsigned SW = DIGIT + 1;

    // One digit of the ripple sum; the extra bit is the carry-out.
    assign {cout, sum} = SW'(x) + SW'(y) + SW'(cin);

endmodule

// File: rtl/hd_serial_alu.sv
// Digit-serial add/sub/floor-average/unsigned-max unit with valid/ready on both sides.
// One operation occupies WIDTH/DIGIT RUN cycles, LSB digit first.
module hd_serial_alu
    import hd_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_carry
);
    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = $clog2(N + 1);

    // Reject digit sizes that do not tile the operand width.
    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0) || (WIDTH > HD_MAX_W)) begin : g_bad_params
        $error("hd_serial_alu: need 1 <= DIGIT <= WIDTH <= %0d and WIDTH a multiple of DIGIT", HD_MAX_W);
    end

    state_e           state_q;
    hd_op_e           op_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             carry_q;
    logic             out_valid_q;
    logic             out_carry_q;
    logic [WIDTH-1:0] out_res_q;
    hd_prep_t         prep_c;
    logic [DIGIT-1:0] sum_c;
    logic             cout_c;

    // Operand pair and carry-in for the beat currently on the input port.
    always_comb begin
        prep_c = hd_prep(hd_op_e'(in_op), HD_MAX_W'(in_a), HD_MAX_W'(in_b));
    end

    hd_digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .x    (x_q[DIGIT-1:0]),
        .y    (y_q[DIGIT-1:0]),
        .cin  (carry_q),
        .sum  (sum_c),
        .cout (cout_c)
    );

    // Result shift register: the new sum digit enters at the top, so after N steps
    // the first (least significant) digit has reached bit 0.
    always_comb begin
        res_d = (res_q >> DIGIT) | (WIDTH'(sum_c) << (WIDTH - DIGIT));
    end

    // Control FSM plus operand, carry and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= HD_ADD;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_carry_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= hd_op_e'(in_op);
                        a_q     <= in_a;
                        b_q     <= in_b;
                        x_q     <= WIDTH'(prep_c.x);
                        y_q     <= WIDTH'(prep_c.y);
                        carry_q <= prep_c.c0;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    x_q     <= x_q >> DIGIT;
                    y_q     <= y_q >> DIGIT;
                    carry_q <= cout_c;
                    res_q   <= res_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_carry_q <= (op_q == HD_AVGF) ? 1'b0 : cout_c;
                        if (op_q == HD_MAXU) begin
                            out_res_q <= cout_c ? a_q : b_q;
                        end else begin
                            out_res_q <= res_d;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;
    assign out_carry = out_carry_q;

endmodule

// File: tb/tb_hd_serial_alu.sv
// Bench for hd_serial_alu: directed cases on an 8/2 instance, then randomized traffic on
// three 16-bit instances (DIGIT 1, 4, 16) against an arithmetic reference model.
module tb_hd_serial_alu;

    localparam int unsigned DW     = 8;
    localparam int unsigned RW     = 16;
    localparam int unsigned NR     = 3;
    localparam int unsigned NOPS   = 1500;
    localparam int unsigned BUDGET = 60000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    // Directed instance
    logic          d_rst_n;
    logic          d_valid;
    logic          d_ready;
    logic [1:0]    d_op;
    logic [DW-1:0] d_a;
    logic [DW-1:0] d_b;
    logic          d_ovalid;
    logic          d_oready;
    logic [DW-1:0] d_res;
    logic          d_carry;

    hd_serial_alu #(.WIDTH(DW), .DIGIT(2)) u_dut (
        .clk       (clk),
        .rst_n     (d_rst_n),
        .in_valid  (d_valid),
        .in_ready  (d_ready),
        .in_op     (d_op),
        .in_a      (d_a),
        .in_b      (d_b),
        .out_valid (d_ovalid),
        .out_ready (d_oready),
        .out_res   (d_res),
        .out_carry (d_carry)
    );

    // Random instances
    logic          r_rst_n;
    logic          r_valid  [NR];
    logic          r_ready  [NR];
    logic [1:0]    r_op     [NR];
    logic [RW-1:0] r_a      [NR];
    logic [RW-1:0] r_b      [NR];
    logic          r_ovalid [NR];
    logic          r_oready [NR];
    logic [RW-1:0] r_res    [NR];
    logic          r_carry  [NR];

    for (genvar g = 0; g < NR; g++) begin : g_rnd
        hd_serial_alu #(.WIDTH(RW), .DIGIT(g == 0 ? 1 : (g == 1 ? 4 : 16))) u_dut (
            .clk       (clk),
            .rst_n     (r_rst_n),
            .in_valid  (r_valid[g]),
            .in_ready  (r_ready[g]),
            .in_op     (r_op[g]),
            .in_a      (r_a[g]),
            .in_b      (r_b[g]),
            .out_valid (r_ovalid[g]),
            .out_ready (r_oready[g]),
            .out_res   (r_res[g]),
            .out_carry (r_carry[g])
        );
    end

    // Scoreboard: expected {carry, result} per accepted beat, in order.
    logic [RW:0]  exp_mem [NR][4096];
    int unsigned  wr_ptr  [NR];
    int unsigned  rd_ptr  [NR];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: the four operations stated as plain unsigned arithmetic on RW-bit values.
    function automatic logic [RW:0] ref_op(input logic [1:0] op, input longint unsigned a,
                                           input longint unsigned b);
        longint unsigned m;
        longint unsigned s;
        longint unsigned res;
        logic            c;
        m = (64'd1 << RW) - 64'd1;
        case (op)
            2'd0: begin s = a + b; res = s & m; c = (s > m); end
            2'd1: begin res = (a - b) & m; c = (a >= b); end
            2'd2: begin res = (a + b) >> 1; c = 1'b0; end
            default: begin res = (a >= b) ? a : b; c = (a >= b); end
        endcase
        return {c, RW'(res)};
    endfunction

    // Offer one beat on the directed instance and wait (bounded) until it is taken.
    task automatic d_issue(input string tag, input logic [1:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
        int unsigned n;
        n = 0;
        d_op = op; d_a = a; d_b = b; d_valid = 1'b1;
        @(negedge clk);
        while (!d_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, 32'(d_ready), 32'd1);
        @(posedge clk); #1;
        d_valid = 1'b0;
        d_op = 2'($urandom_range(3));
        d_a  = DW'($urandom);
        d_b  = DW'($urandom);
    endtask

    // Count cycles from the accept until out_valid, then check the result.
    task automatic d_wait(input string tag, input logic [DW-1:0] er, input logic ec,
                          input int unsigned elat);
        int unsigned lat;
        lat = 1;
        @(negedge clk);
        while (!d_ovalid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_res"}, 32'(d_res), 32'(er));
        check({tag, "_carry"}, 32'(d_carry), 32'(ec));
    endtask

    // Random producer: random gaps, random ops; scrambles inputs once a beat is taken.
    task automatic producer(input int g);
        int unsigned sent;
        int unsigned t0;
        logic        acc;
        sent = 0;
        t0   = cyc;
        while (sent < NOPS && (cyc - t0) < BUDGET) begin
            if (!r_valid[g] && ($urandom_range(3) != 0)) begin
                r_op[g] = 2'($urandom_range(3));
                r_a[g]  = RW'($urandom);
                r_b[g]  = ($urandom_range(7) == 0) ? r_a[g] : RW'($urandom);
                r_valid[g] = 1'b1;
            end
            @(negedge clk);
            acc = r_valid[g] && r_ready[g];
            if (acc) begin
                exp_mem[g][wr_ptr[g]] = ref_op(r_op[g], 64'(r_a[g]), 64'(r_b[g]));
                wr_ptr[g]++;
            end
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                r_valid[g] = 1'b0;
                r_op[g] = 2'($urandom_range(3));
                r_a[g]  = RW'($urandom);
                r_b[g]  = RW'($urandom);
            end
        end
        check($sformatf("rnd%0d_sent", g), 32'(sent), 32'(NOPS));
    endtask

    // Random consumer: random out_ready, checks results in order and hold stability.
    task automatic consumer(input int g);
        int unsigned   got;
        int unsigned   t0;
        logic [RW:0]   e;
        logic          hold;
        logic [RW+1:0] held;
        got  = 0;
        t0   = cyc;
        hold = 1'b0;
        held = '0;
        while (got < NOPS && (cyc - t0) < BUDGET) begin
            r_oready[g] = 1'($urandom_range(1));
            @(negedge clk);
            if (hold) begin
                check($sformatf("rnd%0d_hold", g), 32'({r_ovalid[g], r_carry[g], r_res[g]}),
                      32'(held));
            end
            hold = r_ovalid[g] && !r_oready[g];
            held = {r_ovalid[g], r_carry[g], r_res[g]};
            if (r_ovalid[g] && r_oready[g]) begin
                check($sformatf("rnd%0d_pending", g), 32'(wr_ptr[g] != rd_ptr[g]), 32'd1);
                if (wr_ptr[g] != rd_ptr[g]) begin
                    e = exp_mem[g][rd_ptr[g]];
                    rd_ptr[g]++;
                    check($sformatf("rnd%0d_res#%0d", g, got), 32'(r_res[g]), 32'(e[RW-1:0]));
                    check($sformatf("rnd%0d_carry#%0d", g, got), 32'(r_carry[g]), 32'(e[RW]));
                end
                got++;
            end
            @(posedge clk); #1;
        end
        r_oready[g] = 1'b0;
        check($sformatf("rnd%0d_got", g), 32'(got), 32'(NOPS));
        check($sformatf("rnd%0d_leftover", g), 32'(wr_ptr[g] - rd_ptr[g]), 32'd0);
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: cycle limit reached before the end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned lat;
        int unsigned first;
        int unsigned second;
        int unsigned n;
        logic        seen;

        d_rst_n = 1'b0; r_rst_n = 1'b0;
        d_valid = 1'b0; d_op = 2'd0; d_a = '0; d_b = '0; d_oready = 1'b1;
        for (int g = 0; g < NR; g++) begin
            r_valid[g] = 1'b0; r_op[g] = 2'd0; r_a[g] = '0; r_b[g] = '0; r_oready[g] = 1'b0;
            wr_ptr[g] = 0; rd_ptr[g] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        d_rst_n = 1'b1; r_rst_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", 32'(d_ovalid), 32'd0);
        check("reset_out_res", 32'(d_res), 32'd0);
        check("reset_out_carry", 32'(d_carry), 32'd0);
        check("reset_in_ready", 32'(d_ready), 32'd1);

        // Basic operations, out_ready held high
        d_issue("add_ff_01", 2'd0, 8'hFF, 8'h01);  d_wait("add_ff_01", 8'h00, 1'b1, 5);
        d_issue("sub_05_07", 2'd1, 8'h05, 8'h07);  d_wait("sub_05_07", 8'hFE, 1'b0, 5);
        d_issue("sub_07_07", 2'd1, 8'h07, 8'h07);  d_wait("sub_07_07", 8'h00, 1'b1, 5);
        d_issue("avgf_ff_fd", 2'd2, 8'hFF, 8'hFD); d_wait("avgf_ff_fd", 8'hFE, 1'b0, 5);
        d_issue("maxu_80_7f", 2'd3, 8'h80, 8'h7F); d_wait("maxu_80_7f", 8'h80, 1'b1, 5);
        d_issue("maxu_10_90", 2'd3, 8'h10, 8'h90); d_wait("maxu_10_90", 8'h90, 1'b0, 5);

        // Backpressure: three cycles of out_ready low with a new beat pending
        @(posedge clk); #1;
        d_oready = 1'b0;
        d_issue("bp_first", 2'd0, 8'h12, 8'h01);
        d_wait("bp_first", 8'h13, 1'b0, 5);
        d_op = 2'd1; d_a = 8'h20; d_b = 8'h10; d_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", 32'(d_ovalid), 32'd1);
            check("bp_hold_res", 32'(d_res), 32'h13);
            check("bp_hold_in_ready", 32'(d_ready), 32'd0);
            @(negedge clk);
        end
        check("bp_still_valid", 32'(d_ovalid), 32'd1);
        d_oready = 1'b1;
        @(negedge clk);
        check("bp_after_hs_valid", 32'(d_ovalid), 32'd0);
        check("bp_after_hs_ready", 32'(d_ready), 32'd1);
        @(posedge clk); #1;
        d_valid = 1'b0;
        d_wait("bp_second", 8'h10, 1'b1, 5);

        // Synchronous reset in RUN cycle k=2 discards the operation
        @(posedge clk); #1;
        d_issue("rst_run", 2'd0, 8'hFF, 8'hFF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        d_rst_n = 1'b0;
        @(posedge clk); #1;
        d_rst_n = 1'b1;
        @(negedge clk);
        check("rst_run_out_valid", 32'(d_ovalid), 32'd0);
        check("rst_run_out_res", 32'(d_res), 32'd0);
        check("rst_run_out_carry", 32'(d_carry), 32'd0);
        check("rst_run_in_ready", 32'(d_ready), 32'd1);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | d_ovalid;
        end
        check("rst_run_no_result", 32'(seen), 32'd0);
        d_issue("post_rst_add", 2'd0, 8'h12, 8'h34);
        d_wait("post_rst_add", 8'h46, 1'b0, 5);

        // Throughput: in_valid held high, accepts N+2 = 6 cycles apart
        d_op = 2'd0; d_a = 8'h01; d_b = 8'h02; d_valid = 1'b1;
        first = 0; second = 0; n = 0;
        while (second == 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (d_ready) begin
                if (first == 0) first = cyc;
                else second = cyc;
            end
        end
        check("thru_spacing", 32'(second - first), 32'd6);
        @(posedge clk); #1;
        d_valid = 1'b0;
        d_wait("thru_second", 8'h03, 1'b0, 5);
        @(posedge clk); #1;

        // DIGIT == WIDTH: single RUN cycle, latency 2
        r_op[2] = 2'd0; r_a[2] = 16'hFFFF; r_b[2] = 16'h0001; r_valid[2] = 1'b1; r_oready[2] = 1'b1;
        @(negedge clk);
        check("n1_accept", 32'(r_ready[2]), 32'd1);
        @(posedge clk); #1;
        r_valid[2] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!r_ovalid[2] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("n1_lat", 32'(lat), 32'd2);
        check("n1_res", 32'(r_res[2]), 32'h0000);
        check("n1_carry", 32'(r_carry[2]), 32'd1);
        @(posedge clk); #1;
        r_oready[2] = 1'b0;

        // Randomized traffic on all three 16-bit instances in parallel
        fork
            producer(0);
            consumer(0);
            producer(1);
            consumer(1);
            producer(2);
            consumer(2);
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
